// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_e;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;

  localparam logic [1:0] PC_SRC_PC4  = 2'b00;
  localparam logic [1:0] PC_SRC_BR   = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP = 2'b10;
  localparam logic [1:0] PC_SRC_REG  = 2'b11;

  localparam logic [1:0] REG_DST_RT  = 2'b00;
  localparam logic [1:0] REG_DST_RD  = 2'b01;
  localparam logic [1:0] REG_DST_R31 = 2'b10;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_SHAMT = 2'b10;

  // Immediate-form ALU ops write rt instead of rd.
  function automatic logic is_imm_op(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational half of the control unit: datapath strobes and next state
// from the current state, opcode, ALU zero flag and qualified memory ready.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 3
) (
  input  state_e            state,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  input  logic              ready,
  input  logic              halted,
  output state_e            next_state,
  output logic              pc_we,
  output logic              ir_we,
  output logic              reg_we,
  output logic [1:0]        pc_src,
  output logic [1:0]        reg_dst,
  output logic              wr_data_sel,
  output logic              alu_src_a,
  output logic              alu_src_b,
  output logic [1:0]        ext_sel,
  output logic [ALUOPW-1:0] alu_op,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_to_reg,
  output logic              retire,
  output logic              illegal_det,
  output logic              set_halt
);

  logic [5:0] op6;
  logic       upper_ok;

  assign op6      = opcode[5:0];
  assign upper_ok = ((opcode >> 6) == '0);

  // Per-state strobes; anything a state does not drive stays 0.
  always_comb begin
    next_state  = state;
    pc_we       = 1'b0;
    ir_we       = 1'b0;
    reg_we      = 1'b0;
    pc_src      = PC_SRC_PC4;
    reg_dst     = REG_DST_RT;
    wr_data_sel = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 1'b0;
    ext_sel     = EXT_ZERO;
    alu_op      = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_to_reg  = 1'b0;
    retire      = 1'b0;
    illegal_det = 1'b0;
    set_halt    = 1'b0;
    case (state)
      S_IF: begin
        // A halted core parks here with the memory request dropped.
        if (!halted) begin
          mem_req = 1'b1;
          if (ready) begin
            ir_we      = 1'b1;
            pc_we      = 1'b1;
            next_state = S_ID;
          end
        end
      end
      S_ID: begin
        next_state = S_IF;
        if (!upper_ok) begin
          illegal_det = 1'b1;
        end else begin
          case (op6)
            OP_J: begin
              pc_we  = 1'b1;
              pc_src = PC_SRC_JUMP;
              retire = 1'b1;
            end
            OP_JR: begin
              pc_we  = 1'b1;
              pc_src = PC_SRC_REG;
              retire = 1'b1;
            end
            OP_JAL: begin
              pc_we       = 1'b1;
              pc_src      = PC_SRC_JUMP;
              reg_we      = 1'b1;
              reg_dst     = REG_DST_R31;
              wr_data_sel = 1'b1;
              retire      = 1'b1;
            end
            OP_HALT: begin
              set_halt = 1'b1;
              retire   = 1'b1;
            end
            OP_BEQ, OP_BNE: next_state = S_EXE_BR;
            OP_SW, OP_LW:   next_state = S_EXE_LS;
            OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT:
              next_state = S_EXE_AL;
            default: illegal_det = 1'b1;
          endcase
        end
      end
      S_EXE_AL: begin
        next_state = S_WB_AL;
        case (op6)
          OP_SUB: alu_op = ALUOPW'(ALU_SUB);
          OP_ADDI: begin
            alu_op    = ALUOPW'(ALU_ADD);
            alu_src_b = 1'b1;
            ext_sel   = EXT_SIGN;
          end
          OP_OR:  alu_op = ALUOPW'(ALU_OR);
          OP_AND: alu_op = ALUOPW'(ALU_AND);
          OP_ORI: begin
            alu_op    = ALUOPW'(ALU_OR);
            alu_src_b = 1'b1;
            ext_sel   = EXT_ZERO;
          end
          OP_SLL: begin
            alu_op    = ALUOPW'(ALU_SLL);
            alu_src_a = 1'b1;
            ext_sel   = EXT_SHAMT;
          end
          OP_SLT: begin
            alu_op  = ALUOPW'(ALU_SLT);
            ext_sel = EXT_SIGN;
          end
          default: alu_op = ALUOPW'(ALU_ADD);
        endcase
      end
      S_WB_AL: begin
        reg_we     = 1'b1;
        reg_dst    = is_imm_op(op6) ? REG_DST_RT : REG_DST_RD;
        retire     = 1'b1;
        next_state = S_IF;
      end
      S_EXE_BR: begin
        // BNE inverts the sense of the zero flag.
        alu_op     = ALUOPW'(ALU_SUB);
        pc_src     = PC_SRC_BR;
        pc_we      = zero ^ (op6 == OP_BNE);
        retire     = 1'b1;
        next_state = S_IF;
      end
      S_EXE_LS: begin
        alu_op     = ALUOPW'(ALU_ADD);
        alu_src_b  = 1'b1;
        ext_sel    = EXT_SIGN;
        next_state = S_MEM;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op6 == OP_SW);
        if (ready) begin
          if (op6 == OP_SW) begin
            retire     = 1'b1;
            next_state = S_IF;
          end else begin
            next_state = S_WB_LD;
          end
        end
      end
      S_WB_LD: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        reg_dst    = REG_DST_RT;
        retire     = 1'b1;
        next_state = S_IF;
      end
      default: next_state = S_IF;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle CPU control unit: state register, halt flag, illegal-opcode
// pulse and retired-instruction counter around the combinational decoder.
// Memory handshake: the unit holds mem_req high in IF/MEM and advances only
// in a cycle where mem_ready is high; with MEM_WAIT=0 every access completes
// in its first cycle.
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter int OPW      = 6,
  parameter int ALUOPW   = 3,
  parameter int CNTW     = 32,
  parameter int MEM_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_we,
  output logic              ir_we,
  output logic              reg_we,
  output logic [1:0]        pc_src,
  output logic [1:0]        reg_dst,
  output logic              wr_data_sel,
  output logic              alu_src_a,
  output logic              alu_src_b,
  output logic [1:0]        ext_sel,
  output logic [ALUOPW-1:0] alu_op,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_to_reg,
  output logic              halted,
  output logic              illegal,
  output logic [CNTW-1:0]   retired,
  output logic [2:0]        dbg_state
);

  state_e state;
  state_e next_state;
  logic   ready;
  logic   retire;
  logic   illegal_det;
  logic   set_halt;

  // Ready is forced low while reset is held so no enable fires in reset.
  assign ready     = reset & ((MEM_WAIT != 0) ? mem_ready : 1'b1);
  assign dbg_state = state;

  mc_ctrl_decode #(
    .OPW    (OPW),
    .ALUOPW (ALUOPW)
  ) u_decode (
    .state       (state),
    .opcode      (opcode),
    .zero        (zero),
    .ready       (ready),
    .halted      (halted),
    .next_state  (next_state),
    .pc_we       (pc_we),
    .ir_we       (ir_we),
    .reg_we      (reg_we),
    .pc_src      (pc_src),
    .reg_dst     (reg_dst),
    .wr_data_sel (wr_data_sel),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .ext_sel     (ext_sel),
    .alu_op      (alu_op),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_to_reg  (mem_to_reg),
    .retire      (retire),
    .illegal_det (illegal_det),
    .set_halt    (set_halt)
  );

  // State register plus sticky halt, one-cycle illegal pulse and retire count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IF;
      halted  <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state   <= next_state;
      illegal <= illegal_det;
      if (set_halt) halted <= 1'b1;
      if (retire) retired <= retired + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed bench for mc_ctrl_unit: per-cycle expected control words are
// queued when an instruction is issued and compared as the DUT steps.
module tb_mc_ctrl_unit;
  import mc_ctrl_pkg::*;

  localparam int CW = 4;
  localparam int W  = 27;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode;
  logic zero;
  logic mem_ready;
  logic pc_we, ir_we, reg_we, wr_data_sel, alu_src_a, alu_src_b;
  logic [1:0] pc_src, reg_dst, ext_sel;
  logic [2:0] alu_op;
  logic mem_req, mem_we, mem_to_reg, halted, illegal;
  logic [CW-1:0] retired;
  logic [2:0] dbg_state;

  logic [W-1:0] exp_q[$];
  logic rdy_q[$];
  logic [W-1:0] observed;
  int tests_run = 0;
  int tests_failed = 0;
  logic [CW-1:0] exp_ret;
  logic exp_halt;
  logic ill_pend;
  logic [5:0] tbl [12];

  // Clock
  always #5 clk = ~clk;

  mc_ctrl_unit #(.OPW(6), .ALUOPW(3), .CNTW(CW), .MEM_WAIT(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .pc_src(pc_src), .reg_dst(reg_dst),
    .wr_data_sel(wr_data_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_sel(ext_sel), .alu_op(alu_op), .mem_req(mem_req), .mem_we(mem_we),
    .mem_to_reg(mem_to_reg), .halted(halted), .illegal(illegal), .retired(retired),
    .dbg_state(dbg_state)
  );

  assign observed = {dbg_state, pc_we, ir_we, reg_we, pc_src, reg_dst, wr_data_sel,
                     alu_src_a, alu_src_b, ext_sel, alu_op, mem_req, mem_we, mem_to_reg,
                     halted, illegal, retired};

  function automatic logic [17:0] ctl(input logic pcw, input logic irw, input logic rgw,
                                      input logic [1:0] psrc, input logic [1:0] rdst,
                                      input logic wds, input logic sa, input logic sb,
                                      input logic [1:0] ext, input logic [2:0] aop,
                                      input logic mreq, input logic mwe, input logic m2r);
    return {pcw, irw, rgw, psrc, rdst, wds, sa, sb, ext, aop, mreq, mwe, m2r};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string tag, input logic [W-1:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Scoreboard push: one expected word and the mem_ready to drive that cycle.
  task automatic push(input logic [2:0] st, input logic [17:0] c, input logic rdy);
    exp_q.push_back({st, c, exp_halt, ill_pend, exp_ret});
    rdy_q.push_back(rdy);
    ill_pend = 1'b0;
  endtask

  // Called at a negedge; leaves at a negedge after consuming the queue.
  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front();
      #1;
      check($sformatf("%s c%0d", tag, n), exp_q.pop_front());
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    mem_ready = 1'b0;
    exp_ret = '0;
    exp_halt = 1'b0;
    ill_pend = 1'b0;
    #1;
    check(tag, {3'b000, ctl(0,0,0,2'b00,2'b00,0,0,0,2'b00,3'b000,1,0,0), 1'b0, 1'b0, 4'b0000});
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [17:0] exe_al_ctl(input logic [5:0] op);
    case (op)
      OP_ADD:  return ctl(0,0,0,2'b00,2'b00,0,0,0,EXT_ZERO,ALU_ADD,0,0,0);
      OP_SUB:  return ctl(0,0,0,2'b00,2'b00,0,0,0,EXT_ZERO,ALU_SUB,0,0,0);
      OP_ADDI: return ctl(0,0,0,2'b00,2'b00,0,0,1,EXT_SIGN,ALU_ADD,0,0,0);
      OP_OR:   return ctl(0,0,0,2'b00,2'b00,0,0,0,EXT_ZERO,ALU_OR,0,0,0);
      OP_AND:  return ctl(0,0,0,2'b00,2'b00,0,0,0,EXT_ZERO,ALU_AND,0,0,0);
      OP_ORI:  return ctl(0,0,0,2'b00,2'b00,0,0,1,EXT_ZERO,ALU_OR,0,0,0);
      OP_SLL:  return ctl(0,0,0,2'b00,2'b00,0,1,0,EXT_SHAMT,ALU_SLL,0,0,0);
      default: return ctl(0,0,0,2'b00,2'b00,0,0,0,EXT_SIGN,ALU_SLT,0,0,0);
    endcase
  endfunction

  // Expected cycle-by-cycle behaviour of one whole instruction.
  task automatic expect_instr(input logic [5:0] op, input logic z, input int ifw, input int memw);
    logic [17:0] none;
    none = '0;
    for (int i = 0; i < ifw; i++) push(S_IF, ctl(0,0,0,2'b00,2'b00,0,0,0,2'b00,3'b000,1,0,0), 1'b0);
    push(S_IF, ctl(1,1,0,2'b00,2'b00,0,0,0,2'b00,3'b000,1,0,0), 1'b1);
    case (op)
      OP_J: begin
        push(S_ID, ctl(1,0,0,PC_SRC_JUMP,2'b00,0,0,0,2'b00,3'b000,0,0,0), rnd()); exp_ret++;
      end
      OP_JR: begin
        push(S_ID, ctl(1,0,0,PC_SRC_REG,2'b00,0,0,0,2'b00,3'b000,0,0,0), rnd()); exp_ret++;
      end
      OP_JAL: begin
        push(S_ID, ctl(1,0,1,PC_SRC_JUMP,REG_DST_R31,1,0,0,2'b00,3'b000,0,0,0), rnd()); exp_ret++;
      end
      OP_HALT: begin
        push(S_ID, none, rnd()); exp_ret++; exp_halt = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        push(S_ID, none, rnd());
        push(S_EXE_BR, ctl(z ^ (op == OP_BNE),0,0,PC_SRC_BR,2'b00,0,0,0,2'b00,ALU_SUB,0,0,0), rnd());
        exp_ret++;
      end
      OP_SW, OP_LW: begin
        push(S_ID, none, rnd());
        push(S_EXE_LS, ctl(0,0,0,2'b00,2'b00,0,0,1,EXT_SIGN,ALU_ADD,0,0,0), rnd());
        for (int i = 0; i < memw; i++)
          push(S_MEM, ctl(0,0,0,2'b00,2'b00,0,0,0,2'b00,3'b000,1,op == OP_SW,0), 1'b0);
        push(S_MEM, ctl(0,0,0,2'b00,2'b00,0,0,0,2'b00,3'b000,1,op == OP_SW,0), 1'b1);
        if (op == OP_SW) exp_ret++;
        else begin
          push(S_WB_LD, ctl(0,0,1,2'b00,REG_DST_RT,0,0,0,2'b00,3'b000,0,0,1), rnd()); exp_ret++;
        end
      end
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT: begin
        push(S_ID, none, rnd());
        push(S_EXE_AL, exe_al_ctl(op), rnd());
        push(S_WB_AL, ctl(0,0,1,2'b00,(op == OP_ADDI || op == OP_ORI) ? REG_DST_RT : REG_DST_RD,
                          0,0,0,2'b00,3'b000,0,0,0), rnd());
        exp_ret++;
      end
      default: begin
        push(S_ID, none, rnd());
        ill_pend = 1'b1;
      end
    endcase
  endtask

  task automatic run(input string tag, input logic [5:0] op, input logic z, input int ifw, input int memw);
    opcode = op;
    zero = z;
    expect_instr(op, z, ifw, memw);
    drain(tag);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Directed sequence
  initial begin
    reset = 1'b0; opcode = OP_ADD; zero = 1'b0; mem_ready = 1'b0;
    exp_ret = '0; exp_halt = 1'b0; ill_pend = 1'b0;
    tbl = '{OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT, OP_SW, OP_J, OP_JR, OP_BEQ, OP_BNE};
    @(negedge clk);
    do_reset("reset_init");

    run("add", OP_ADD, 1'b0, 0, 0);
    run("lw_waits", OP_LW, 1'b0, 2, 3);
    run("beq_z1", OP_BEQ, 1'b1, 0, 0);
    run("bne_z1", OP_BNE, 1'b1, 0, 0);
    run("jal", OP_JAL, 1'b0, 0, 0);
    run("illegal", 6'b101010, 1'b0, 0, 0);

    for (int i = 0; i < 12; i++)
      run($sformatf("tbl%0d", i), tbl[i], rnd(), $urandom_range(0, 2), $urandom_range(0, 2));

    // Abandon a load while it waits in MEM.
    opcode = OP_LW;
    push(S_IF, ctl(1,1,0,2'b00,2'b00,0,0,0,2'b00,3'b000,1,0,0), 1'b1);
    push(S_ID, '0, 1'b1);
    push(S_EXE_LS, ctl(0,0,0,2'b00,2'b00,0,0,1,EXT_SIGN,ALU_ADD,0,0,0), 1'b1);
    push(S_MEM, ctl(0,0,0,2'b00,2'b00,0,0,0,2'b00,3'b000,1,0,0), 1'b0);
    push(S_MEM, ctl(0,0,0,2'b00,2'b00,0,0,0,2'b00,3'b000,1,0,0), 1'b0);
    drain("lw_partial");
    do_reset("reset_mid_mem");
    run("after_rst", OP_ADD, 1'b0, 0, 0);

    // Counter wrap: one ADD already retired, 15 more reach 16 mod 16.
    for (int i = 0; i < 15; i++) run($sformatf("wrap%0d", i), OP_ADD, 1'b0, 0, 0);
    tests_run++;
    assert (retired === 4'd0) else begin
      tests_failed++;
      $error("FAIL retired_wrap: observed %0d expected 0", retired);
    end

    run("halt", OP_HALT, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) push(S_IF, '0, rnd());
    drain("halted_idle");
    do_reset("halt_clear");
    run("post_halt", OP_ADD, 1'b0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
